// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux8
//  Purpose  : Receive-side TDM demultiplexer. Rebuilds eight parallel channels
//             from a slot-serial stream. Slot 0 is marked by frame_sync. Once
//             the first sync is seen, the block locks and counts slots on its
//             own (flywheel). Each complete frame is presented on o0..o7
//             together with a one-cycle frame_valid strobe.
//  Ports    : clk         - rising-edge clock
//             rst_n       - synchronous active-low reset
//             din         - sample for the current slot (W bits)
//             din_valid   - qualifies din and frame_sync
//             frame_sync  - marks the qualified sample as slot 0
//             o0..o7      - registered channel outputs (last complete frame)
//             frame_valid - one-cycle pulse when o0..o7 take a new frame
//             locked      - high once a sync has been seen (until reset)
//             sync_err    - one-cycle pulse on a sync at a non-zero slot
//             slot        - index of the next expected slot
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux8 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic [W-1:0] o4,
  output logic [W-1:0] o5,
  output logic [W-1:0] o6,
  output logic [W-1:0] o7,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err,
  output logic [2:0]   slot
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  logic [2:0]          r_slot;
  // Slot 7 is never stored: it is taken straight from din when the frame
  // completes, so only slots 0..6 need shadow storage.
  logic [6:0][W-1:0]   r_shadow;
  logic [7:0][W-1:0]   r_out;
  logic                r_frame_valid;
  logic                r_sync_err;
  logic                r_locked;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= HUNT;
      r_slot        <= 3'd0;
      r_shadow      <= '0;
      r_out         <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      // Pulses are low unless an event below raises them this cycle.
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;

      if (din_valid) begin
        case (r_state)
          HUNT: begin
            if (frame_sync) begin
              r_shadow[0] <= din;
              r_slot      <= 3'd1;
              r_state     <= LOCKED;
              r_locked    <= 1'b1;
            end
          end

          LOCKED: begin
            if (frame_sync && (r_slot != 3'd0)) begin
              // Misaligned sync: drop the partial frame and restart at slot 0
              // with this sample. Outputs keep the previous frame.
              r_sync_err  <= 1'b1;
              r_shadow[0] <= din;
              r_slot      <= 3'd1;
            end else if (r_slot == 3'd7) begin
              r_out         <= {din, r_shadow};
              r_frame_valid <= 1'b1;
              r_slot        <= 3'd0;
            end else begin
              for (int i = 0; i < 7; i++) begin
                if (r_slot == 3'(i)) begin
                  r_shadow[i] <= din;
                end
              end
              r_slot <= r_slot + 3'd1;
            end
          end

          default: begin
            r_state <= HUNT;
          end
        endcase
      end
    end
  end

  assign o0          = r_out[0];
  assign o1          = r_out[1];
  assign o2          = r_out[2];
  assign o3          = r_out[3];
  assign o4          = r_out[4];
  assign o5          = r_out[5];
  assign o6          = r_out[6];
  assign o7          = r_out[7];
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = r_locked;
  assign slot        = r_slot;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux8
//  Purpose  : Directed self-checking bench for tdm_demux8 with W=1. Frames are
//             written as bytes where bit i is the sample for slot i, so the
//             same byte is the expected {o7..o0} after completion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [0:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;
  logic [2:0] slot;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fv_cyc_a;
  int fv_cyc_b;
  int fv_count;

  logic [7:0] w_outs;
  assign w_outs = {o7, o6, o5, o4, o3, o2, o1, o0};

  tdm_demux8 #(.W(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .o0          (o0),
    .o1          (o1),
    .o2          (o2),
    .o3          (o3),
    .o4          (o4),
    .o5          (o5),
    .o6          (o6),
    .o7          (o7),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .slot        (slot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns #1 after the edge.
  task automatic step(input logic r, input logic d, input logic v, input logic fs);
    @(negedge clk);
    rst_n      = r;
    din        = d;
    din_valid  = v;
    frame_sync = fs;
    @(posedge clk);
    #1;
    if (frame_valid) fv_count++;
  endtask

  task automatic send(input logic d, input logic fs);
    step(1'b1, d, 1'b1, fs);
  endtask

  // Eight consecutive valid samples; slot i carries bits[i].
  task automatic send_frame(input string tag, input logic [7:0] bits, input logic sync_first);
    for (int i = 0; i < 8; i++) begin
      send(bits[i], sync_first && (i == 0));
      if (i < 7) chk({tag, "_fv_low"}, frame_valid, 1'b0);
    end
    chk({tag, "_fv"}, frame_valid, 1'b1);
    chk({tag, "_data"}, w_outs, bits);
    chk({tag, "_slot"}, slot, 3'd0);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b1; din_valid = 1'b1; frame_sync = 1'b1;
    fv_count = 0;

    // Reset held for 3 clocks with sync/valid active.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_outs", w_outs, 8'h00);
    chk("rst_locked", locked, 1'b0);
    chk("rst_slot", slot, 3'd0);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_fv_count", fv_count, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Basic frame 1,0,1,1,0,0,1,0.
    send(1'b1, 1'b1);
    chk("basic_locked_early", locked, 1'b1);
    chk("basic_slot1", slot, 3'd1);
    for (int i = 1; i < 8; i++) send(8'h4D >> i, 1'b0);
    chk("basic_fv", frame_valid, 1'b1);
    chk("basic_data", w_outs, 8'h4D);
    chk("basic_locked", locked, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("basic_fv_once", frame_valid, 1'b0);
    chk("basic_hold", w_outs, 8'h4D);

    // Reset, then pre-sync garbage, then a frame with 1,0 valid toggling.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst2_outs", w_outs, 8'h00);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    chk("garbage_locked", locked, 1'b0);
    chk("garbage_slot", slot, 3'd0);
    fv_count = 0;
    for (int i = 0; i < 8; i++) begin
      send(8'h96 >> i, i == 0);
      if (i == 7) begin
        chk("gap_fv", frame_valid, 1'b1);
        chk("gap_data", w_outs, 8'h96);
      end
      // Invalid cycle with inverted data and a stray sync: must be ignored.
      step(1'b1, ~(8'h96 >> i), 1'b0, 1'b1);
    end
    chk("gap_fv_count", fv_count, 1);
    chk("gap_hold", w_outs, 8'h96);

    // Flywheel: two back-to-back frames, sync on the first only.
    send_frame("fly_a", 8'hF3, 1'b1);
    fv_cyc_a = cyc;
    send_frame("fly_b", 8'h68, 1'b0);
    fv_cyc_b = cyc;
    chk("fly_spacing", fv_cyc_b - fv_cyc_a, 8);

    // Misalignment: sync on the 4th sample of a frame.
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    chk("mis_err", sync_err, 1'b1);
    chk("mis_fv", frame_valid, 1'b0);
    chk("mis_hold", w_outs, 8'h68);
    chk("mis_slot", slot, 3'd1);
    for (int i = 1; i < 8; i++) begin
      send(8'h81 >> i, 1'b0);
      if (i == 1) chk("mis_err_pulse", sync_err, 1'b0);
      if (i < 7) chk("mis_fv_low", frame_valid, 1'b0);
    end
    chk("mis_next_fv", frame_valid, 1'b1);
    chk("mis_next_data", w_outs, 8'h81);

    // Reset mid-frame after slot 5.
    for (int i = 0; i < 6; i++) send(1'b1, i == 0);
    chk("mid_slot6", slot, 3'd6);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("mid_outs", w_outs, 8'h00);
    chk("mid_locked", locked, 1'b0);
    chk("mid_slot", slot, 3'd0);
    fv_count = 0;
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0);
    chk("mid_nosync_fv", fv_count, 0);
    chk("mid_nosync_locked", locked, 1'b0);
    send_frame("mid_resync", 8'hAA, 1'b1);
    chk("mid_resync_locked", locked, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive-side counterpart of the team's 8:1 mux.
- Takes a time-division-multiplexed stream (one channel per slot, slot index = {s2,s1,s0} on the transmit side) and rebuilds eight parallel channel outputs.
- Slot 0 is marked by frame_sync. After frame_sync is first seen, the block locks and counts slots itself (flywheel). It presents a complete, registered 8-channel frame with a one-cycle frame_valid strobe.

Parameters:
- W, 1, width of each channel sample (din and each oN).

Ports:
- clk  in  1  rising-edge clock; all state updates on this edge.
- rst_n  in  1  reset, synchronous, active-low. Sampled on the clk rising edge; low clears all state.
- din  in  W  serial TDM sample for the current slot.
- din_valid  in  1  din and frame_sync are qualified on cycles where this is 1. Both are ignored when it is 0.
- frame_sync  in  1  marks the sample as slot 0; qualified by din_valid.
- o0..o7  out  W each  reconstructed channel outputs. Registered; hold the last complete frame.
- frame_valid  out  1  one-cycle pulse when o0..o7 update with a new complete frame.
- locked  out  1  1 in state LOCKED.
- sync_err  out  1  one-cycle pulse when frame_sync arrives at a slot other than 0 while LOCKED.
- slot  out  3  index of the next slot expected (0..7).

Behaviour:
- Reset (rst_n=0 at clk edge): state=HUNT, slot=0, shadow regs=0, o0..o7=0, frame_valid=0, sync_err=0, locked=0. Reset overrides all other inputs. Reset mid-frame discards the partial frame; outputs go to 0.
- Accepted sample: a cycle with din_valid=1. Cycles with din_valid=0 change nothing except clearing the pulses (frame_valid and sync_err are 0 on any cycle without a triggering event).
- HUNT:
  - Accepted sample with frame_sync=0: discarded.
  - Accepted sample with frame_sync=1: shadow[0]<=din, slot<=1, state<=LOCKED.
- LOCKED, accepted sample, frame_sync=0:
  - shadow[slot]<=din, slot<=slot+1 (3-bit wrap 7->0).
  - frame_sync absent at slot 0 is legal (flywheel); the sample is stored as slot 0.
- LOCKED, accepted sample, frame_sync=1, slot==0: normal slot-0 store, slot<=1.
- LOCKED, accepted sample, frame_sync=1, slot!=0 (misalignment):
  - sync_err=1 next cycle.
  - Partial frame discarded; outputs unchanged, no frame_valid.
  - shadow[0]<=din, slot<=1, state stays LOCKED.
- Frame completion (accepted sample at slot 7 without a misaligning frame_sync):
  - On that edge: o0..o6<=shadow[0..6], o7<=din (bypass), slot<=0.
  - frame_valid=1 for exactly the following cycle.
  - Latency: outputs and frame_valid are visible one cycle after the slot-7 sample is accepted.
- Back-to-back frames at full rate (din_valid held 1) give one frame_valid pulse every 8 cycles.
- Any din_valid gaps stretch the frame; gaps do not affect alignment.
- Outputs hold their value between completions. No output changes combinationally from inputs.
- locked is a registered copy of (state==LOCKED). The block never returns to HUNT except through reset.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with din_valid=1, frame_sync=1 -> o0..o7=0, locked=0, slot=0, no frame_valid.
- Basic frame (W=1): sync on the first sample, din sequence 1,0,1,1,0,0,1,0 over 8 consecutive valid cycles -> one cycle after the 8th sample, o0..o7=1,0,1,1,0,0,1,0, frame_valid high for 1 cycle, locked=1.
- Pre-sync garbage and gaps: 5 valid samples with frame_sync=0, then a frame with din_valid toggling 1,0 each cycle -> garbage ignored, frame reconstructed correctly after 16 cycles, single frame_valid pulse.
- Flywheel: two back-to-back frames, frame_sync only on the first -> two frame_valid pulses exactly 8 cycles apart, second frame data correct.
- Misalignment: assert frame_sync on the 4th sample of a frame -> sync_err pulse, no frame_valid for the partial frame, the following 8 samples from that sync form the next frame with correct o0..o7.
- Reset mid-frame: rst_n=0 after slot 5 -> outputs 0, locked=0; a new sync is needed before the next frame.
